// File: rtl/csi_rx_pkg.sv
// Shared definitions for the CSI-2 receive lane logic.
//   lane_sync_state_t : state encoding of the per-lane bring-up / lock FSM
//   CSI_SYNC_BYTE     : sync byte the word aligner searches for
//   *_cnt_w()         : counter width helpers; the *_DEF localparams are the
//                       widths for the default block parameters
package csi_rx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SERDES_RST,
    ST_TAP_SET,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL,
    ST_FINALIZE,
    ST_APPLY,
    ST_APPLY_SETTLE,
    ST_LOCKED
  } lane_sync_state_t;

  localparam logic [7:0] CSI_SYNC_BYTE = 8'hB8;

  // Hit counter saturates at min_hits, so it must hold the value min_hits.
  function automatic int hit_cnt_w(input int min_hits);
    return (min_hits < 1) ? 1 : $clog2(min_hits + 1);
  endfunction

  // Window counter runs 0..window_cyc-1.
  function automatic int window_cnt_w(input int window_cyc);
    return (window_cyc < 2) ? 1 : $clog2(window_cyc);
  endfunction

  // Timeout counter carries one spare bit above the terminal count.
  function automatic int timeout_cnt_w(input int lock_timeout);
    return $clog2(lock_timeout) + 1;
  endfunction

  localparam int HIT_CNT_W_DEF     = hit_cnt_w(4);
  localparam int WINDOW_CNT_W_DEF  = window_cnt_w(1024);
  localparam int TIMEOUT_CNT_W_DEF = timeout_cnt_w(65536);

endpackage

// File: rtl/csi_rx_tap_scorer.sv
// Pass/fail run tracker for the IDELAY tap sweep.
// Tracks the currently open run of passing taps and the best (longest) run
// seen so far, and presents the centre tap of the best run.
//   byte_clock  : clock
//   reset_n     : synchronous active-low reset
//   clear       : synchronous clear of all run trackers (start of a sweep)
//   eval        : one-cycle strobe, score tap `tap` with result `pass`
//   pass        : current tap passed
//   tap         : tap being scored
//   last        : tap is the highest tap; any open run is closed
//   best_empty  : no passing tap found in this sweep
//   best_centre : best_start + floor((best_len-1)/2)
module csi_rx_tap_scorer #(
  parameter int TAP_W = 5
) (
  input  logic             byte_clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             eval,
  input  logic             pass,
  input  logic [TAP_W-1:0] tap,
  input  logic             last,
  output logic             best_empty,
  output logic [TAP_W-1:0] best_centre
);

  // Lengths are one bit wider than a tap so a full-range run fits.
  logic [TAP_W-1:0] cur_start;
  logic [TAP_W:0]   cur_len;
  logic [TAP_W-1:0] best_start;
  logic [TAP_W:0]   best_len;

  logic [TAP_W-1:0] run_start;
  logic [TAP_W:0]   run_len;
  logic             close_run;

  // Run as it stands after including this tap's result.
  always_comb begin
    run_start = (pass && (cur_len == '0)) ? tap : cur_start;
    run_len   = pass ? (cur_len + 1'b1) : cur_len;
    close_run = !pass || last;
  end

  assign best_empty  = (best_len == '0);
  assign best_centre = best_start + TAP_W'((best_len - 1'b1) >> 1);

  always_ff @(posedge byte_clock) begin
    if (!reset_n || clear) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (eval) begin
      // Strict compare: on equal length the earlier (lower-tap) run stays.
      if (close_run && (run_len > best_len)) begin
        best_start <= run_start;
        best_len   <= run_len;
      end
      cur_start <= run_start;
      cur_len   <= close_run ? '0 : run_len;
    end
  end

endmodule

// File: rtl/csi_rx_lane_sync_ctrl.sv
// Per-lane bring-up and lock controller (byte-clock domain).
// Waits for the clock detector, resets the ISERDES, sweeps IDELAY taps
// scoring sync-word hits, loads the centre of the longest passing run and
// then watches for loss of lock, re-sweeping when it is lost.
//   byte_clock     : lane byte clock (only clock)
//   reset_n        : synchronous active-low reset
//   clkdet_reset   : high while the byte clock is not stable; forces IDLE
//   clkdet_enable  : clock detector enable (1 out of reset)
//   serdes_reset   : ISERDES reset
//   tap_value      : IDELAY tap, valid in the cycle tap_load is high
//   tap_load       : one-cycle tap load strobe
//   aligner_enable : word aligner enable
//   sync_hit       : one-cycle pulse per sync word found by the aligner
//   locked         : lane locked
//   best_tap       : last selected tap
//   retry_cnt      : saturating count of failed sweeps plus lock losses
//   dbg_state      : current FSM state
module csi_rx_lane_sync_ctrl
  import csi_rx_pkg::*;
#(
  parameter int TAP_W          = 5,
  parameter int SERDES_RST_CYC = 8,
  parameter int SETTLE_CYC     = 16,
  parameter int WINDOW_CYC     = 1024,
  parameter int MIN_HITS       = 4,
  parameter int LOCK_TIMEOUT   = 65536
) (
  input  logic             byte_clock,
  input  logic             reset_n,
  input  logic             clkdet_reset,
  output logic             clkdet_enable,
  output logic             serdes_reset,
  output logic [TAP_W-1:0] tap_value,
  output logic             tap_load,
  output logic             aligner_enable,
  input  logic             sync_hit,
  output logic             locked,
  output logic [TAP_W-1:0] best_tap,
  output logic [7:0]       retry_cnt,
  output lane_sync_state_t dbg_state
);

  localparam int HIT_W   = hit_cnt_w(MIN_HITS);
  localparam int WIN_W   = window_cnt_w(WINDOW_CYC);
  localparam int TO_W    = timeout_cnt_w(LOCK_TIMEOUT);
  localparam int DLY_MAX = (SERDES_RST_CYC > SETTLE_CYC) ? SERDES_RST_CYC : SETTLE_CYC;
  localparam int DLY_W   = $clog2(DLY_MAX) + 1;

  localparam logic [DLY_W-1:0] SR_LAST  = DLY_W'(SERDES_RST_CYC - 1);
  localparam logic [DLY_W-1:0] SET_LAST = DLY_W'(SETTLE_CYC - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [HIT_W-1:0] HIT_SAT  = HIT_W'(MIN_HITS);
  localparam logic [TAP_W-1:0] TAP_MAX  = '1;

  lane_sync_state_t state;
  logic [TAP_W-1:0] tap_idx;
  logic [DLY_W-1:0] dly_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [HIT_W-1:0] hit_cnt;
  logic [TO_W-1:0]  to_cnt;

  logic             score_eval;
  logic             best_empty;
  logic [TAP_W-1:0] best_centre;

  assign dbg_state  = state;
  assign score_eval = (state == ST_EVAL) && !clkdet_reset;

  csi_rx_tap_scorer #(.TAP_W(TAP_W)) u_scorer (
    .byte_clock  (byte_clock),
    .reset_n     (reset_n),
    .clear       (state == ST_SERDES_RST),
    .eval        (score_eval),
    .pass        (hit_cnt == HIT_SAT),
    .tap         (tap_idx),
    .last        (tap_idx == TAP_MAX),
    .best_empty  (best_empty),
    .best_centre (best_centre)
  );

  // Outputs are registered alongside the state: each transition sets the
  // output values of the state being entered.
  always_ff @(posedge byte_clock) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      clkdet_enable  <= 1'b0;
      serdes_reset   <= 1'b1;
      tap_value      <= '0;
      tap_load       <= 1'b0;
      aligner_enable <= 1'b0;
      locked         <= 1'b0;
      best_tap       <= '0;
      retry_cnt      <= '0;
      tap_idx        <= '0;
      dly_cnt        <= '0;
      win_cnt        <= '0;
      hit_cnt        <= '0;
      to_cnt         <= '0;
    end else begin
      clkdet_enable <= 1'b1;
      tap_load      <= 1'b0;
      if (clkdet_reset) begin
        // Unstable byte clock: back to IDLE, status (best_tap/retry) kept.
        state          <= ST_IDLE;
        serdes_reset   <= 1'b1;
        aligner_enable <= 1'b0;
        locked         <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_SERDES_RST;
            dly_cnt <= '0;
          end
          ST_SERDES_RST: begin
            tap_idx <= '0;
            if (dly_cnt == SR_LAST) begin
              state        <= ST_TAP_SET;
              serdes_reset <= 1'b0;
              tap_value    <= '0;
              tap_load     <= 1'b1;
            end else begin
              dly_cnt <= dly_cnt + 1'b1;
            end
          end
          ST_TAP_SET: begin
            state   <= ST_SETTLE;
            dly_cnt <= '0;
          end
          ST_SETTLE: begin
            if (dly_cnt == SET_LAST) begin
              state          <= ST_MEASURE;
              aligner_enable <= 1'b1;
              win_cnt        <= '0;
              hit_cnt        <= '0;
            end else begin
              dly_cnt <= dly_cnt + 1'b1;
            end
          end
          ST_MEASURE: begin
            // A hit in the final window cycle still counts.
            if (sync_hit && (hit_cnt != HIT_SAT)) hit_cnt <= hit_cnt + 1'b1;
            if (win_cnt == WIN_LAST) begin
              state          <= ST_EVAL;
              aligner_enable <= 1'b0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
            end
          end
          ST_EVAL: begin
            // The tap index never wraps; the top tap ends the sweep.
            if (tap_idx == TAP_MAX) begin
              state <= ST_FINALIZE;
            end else begin
              tap_idx   <= tap_idx + 1'b1;
              tap_value <= tap_idx + 1'b1;
              tap_load  <= 1'b1;
              state     <= ST_TAP_SET;
            end
          end
          ST_FINALIZE: begin
            if (best_empty) begin
              if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
              state        <= ST_SERDES_RST;
              serdes_reset <= 1'b1;
              dly_cnt      <= '0;
            end else begin
              best_tap  <= best_centre;
              tap_value <= best_centre;
              tap_load  <= 1'b1;
              state     <= ST_APPLY;
            end
          end
          ST_APPLY: begin
            state   <= ST_APPLY_SETTLE;
            dly_cnt <= '0;
          end
          ST_APPLY_SETTLE: begin
            if (dly_cnt == SET_LAST) begin
              state          <= ST_LOCKED;
              aligner_enable <= 1'b1;
              locked         <= 1'b1;
              to_cnt         <= '0;
            end else begin
              dly_cnt <= dly_cnt + 1'b1;
            end
          end
          ST_LOCKED: begin
            // to_cnt = consecutive hit-free cycles so far; a hit in the
            // would-be timeout cycle cancels the timeout.
            if (sync_hit) begin
              to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
              if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
              locked         <= 1'b0;
              aligner_enable <= 1'b0;
              serdes_reset   <= 1'b1;
              dly_cnt        <= '0;
              state          <= ST_SERDES_RST;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
